// File: rtl/data_mem_ctrl_if.sv
// Purpose : request/response bundle between the CPU data path and data_mem_ctrl.
// Latency : n/a (wires only); the memory answers reads one edge after acceptance.
// Backpr. : Ready low means requests are ignored; no other throttling.
// Signals : Req/Write/Addr/Byte_En/Data_In (master -> memory),
//           Ready/Data_Out/Rd_Valid/Addr_Err (memory -> master).
interface data_mem_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic                  Req;
  logic                  Write;
  logic [ADDR_W-1:0]     Addr;
  logic [DATA_W/8-1:0]   Byte_En;
  logic [DATA_W-1:0]     Data_In;
  logic                  Ready;
  logic [DATA_W-1:0]     Data_Out;
  logic                  Rd_Valid;
  logic                  Addr_Err;

  modport master (
    output Req, Write, Addr, Byte_En, Data_In,
    input  Ready, Data_Out, Rd_Valid, Addr_Err
  );

  modport slave (
    input  Req, Write, Addr, Byte_En, Data_In,
    output Ready, Data_Out, Rd_Valid, Addr_Err
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// Purpose : parametrised word-addressed data memory with byte enables, range
//           flagging and an optional zeroing sweep after reset.
// Latency : writes land on the accepting edge; reads are valid one edge later.
// Backpr. : Ready=0 during reset and the clear sweep; otherwise one request
//           per cycle with no stalls.
// Ports   : Clk, Rst_n (sync, active-low); bus = data_mem_ctrl_if.slave.
module data_mem_ctrl #(
  parameter int DATA_W     = 16,
  parameter int DEPTH      = 64,
  parameter int ADDR_W     = 16,
  parameter int INIT_CLEAR = 1
) (
  input  logic            Clk,
  input  logic            Rst_n,
  data_mem_ctrl_if.slave  bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int NB    = DATA_W / 8;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;
  logic               ready_q, ready_d;
  logic [DATA_W-1:0]  data_out_q, data_out_d;
  logic               rd_valid_q, rd_valid_d;
  logic               addr_err_q, addr_err_d;

  logic [DATA_W-1:0]  mem [DEPTH];

  logic               in_range;
  logic               acc;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   mem_waddr;
  logic [NB-1:0]      mem_wbe;
  logic [DATA_W-1:0]  mem_wdata;

  // Only the bits above the index field decide range; no wrap-around.
  assign in_range = ((bus.Addr >> IDX_W) == '0);
  assign idx      = bus.Addr[IDX_W-1:0];

  // State register
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q <= (INIT_CLEAR != 0) ? S_CLEAR : S_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == S_CLEAR) begin
      cnt_d = cnt_q + IDX_W'(1);
      if (cnt_q == LAST_IDX) begin
        state_d = S_RUN;
      end
    end
  end

  // Output / datapath control
  always_comb begin
    // Ready is a registered copy of the RUN state, so it lags the FSM by one
    // edge; requests are only honoured once Ready is actually high.
    ready_d    = (state_q == S_RUN);
    acc        = ready_q && (state_q == S_RUN) && bus.Req;
    rd_valid_d = acc && !bus.Write;
    addr_err_d = acc && !in_range;
    data_out_d = data_out_q;
    if (rd_valid_d) begin
      data_out_d = in_range ? mem[idx] : '0;
    end

    mem_waddr = idx;
    mem_wdata = bus.Data_In;
    mem_wbe   = '0;
    if (state_q == S_CLEAR) begin
      mem_waddr = cnt_q;
      mem_wdata = '0;
      mem_wbe   = '1;
    end else if (acc && bus.Write && in_range) begin
      mem_wbe   = bus.Byte_En;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      ready_q    <= 1'b0;
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      ready_q    <= ready_d;
      data_out_q <= data_out_d;
      rd_valid_q <= rd_valid_d;
      addr_err_q <= addr_err_d;
    end
  end

  // Array is never reset; a write coinciding with reset is suppressed.
  always_ff @(posedge Clk) begin
    if (Rst_n) begin
      for (int b = 0; b < NB; b++) begin
        if (mem_wbe[b]) begin
          mem[mem_waddr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
      end
    end
  end

  assign bus.Ready    = ready_q;
  assign bus.Data_Out = data_out_q;
  assign bus.Rd_Valid = rd_valid_q;
  assign bus.Addr_Err = addr_err_q;
endmodule

// File: tb/tb_data_mem_ctrl.sv
module tb_data_mem_ctrl;
  logic clk = 1'b0;
  logic rst_a_n = 1'b0;
  logic rst_b_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [15:0] exp_a [64];

  always #5 clk = ~clk;

  data_mem_ctrl_if #(.DATA_W(16), .ADDR_W(16)) ifa ();
  data_mem_ctrl_if #(.DATA_W(32), .ADDR_W(16)) ifb ();

  data_mem_ctrl #(.DATA_W(16), .DEPTH(64), .ADDR_W(16), .INIT_CLEAR(1)) u_a (
    .Clk(clk), .Rst_n(rst_a_n), .bus(ifa)
  );
  data_mem_ctrl #(.DATA_W(32), .DEPTH(16), .ADDR_W(16), .INIT_CLEAR(0)) u_b (
    .Clk(clk), .Rst_n(rst_b_n), .bus(ifb)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op_a(input logic req, input logic wr, input logic [15:0] addr,
                      input logic [1:0] be, input logic [15:0] d);
    ifa.Req = req; ifa.Write = wr; ifa.Addr = addr; ifa.Byte_En = be; ifa.Data_In = d;
    tick();
  endtask

  task automatic wr_a(input logic [15:0] addr, input logic [1:0] be, input logic [15:0] d);
    op_a(1'b1, 1'b1, addr, be, d);
    if (addr < 16'd64) begin
      for (int b = 0; b < 2; b++)
        if (be[b]) exp_a[addr[5:0]][8*b +: 8] = d[8*b +: 8];
    end
  endtask

  task automatic op_b(input logic req, input logic wr, input logic [15:0] addr,
                      input logic [3:0] be, input logic [31:0] d);
    ifb.Req = req; ifb.Write = wr; ifb.Addr = addr; ifb.Byte_En = be; ifb.Data_In = d;
    tick();
  endtask

  // Ticks until Ready is seen high (bounded), counting any output pulses.
  task automatic wait_ready_a(output int n, output int pulses);
    n = 0;
    pulses = 0;
    while (!ifa.Ready && n < 200) begin
      tick();
      n++;
      if (ifa.Rd_Valid) pulses++;
      if (ifa.Addr_Err) pulses++;
    end
  endtask

  initial begin
    int n;
    int p;
    ifa.Req = 0; ifa.Write = 0; ifa.Addr = '0; ifa.Byte_En = '0; ifa.Data_In = '0;
    ifb.Req = 0; ifb.Write = 0; ifb.Addr = '0; ifb.Byte_En = '0; ifb.Data_In = '0;

    // ---------------- DUT A: 16 x 64, with clear sweep ----------------
    tick(); tick();
    check("a_rst_ready", 32'(ifa.Ready), 32'd0);
    check("a_rst_rdvalid", 32'(ifa.Rd_Valid), 32'd0);
    check("a_rst_adderr", 32'(ifa.Addr_Err), 32'd0);
    check("a_rst_dout", 32'(ifa.Data_Out), 32'd0);

    // First sweep; reads requested throughout must be ignored.
    ifa.Req = 1; ifa.Write = 0; ifa.Addr = 16'd5;
    rst_a_n = 1;
    wait_ready_a(n, p);
    check("a_sweep1_latency", 32'(n), 32'd65);
    check("a_sweep1_pulses", 32'(p), 32'd0);

    // Preload word 5, then reset and let the sweep wipe it.
    wr_a(16'd5, 2'b11, 16'h000A);
    op_a(1, 0, 16'd5, 2'b00, 16'h0);
    check("a_preload_rd", 32'(ifa.Data_Out), 32'h000A);
    rst_a_n = 0;
    op_a(0, 0, 16'd0, 2'b00, 16'h0);
    rst_a_n = 1;
    ifa.Req = 1; ifa.Write = 1; ifa.Addr = 16'd9; ifa.Byte_En = 2'b11; ifa.Data_In = 16'hFFFF;
    wait_ready_a(n, p);
    check("a_sweep2_latency", 32'(n), 32'd65);
    check("a_sweep2_pulses", 32'(p), 32'd0);
    for (int i = 0; i < 64; i++) exp_a[i] = 16'h0000;
    op_a(1, 0, 16'd5, 2'b00, 16'h0);
    check("a_cleared_w5", 32'(ifa.Data_Out), 32'h0000);
    check("a_cleared_w5_rv", 32'(ifa.Rd_Valid), 32'd1);
    op_a(1, 0, 16'd9, 2'b00, 16'h0);
    check("a_sweep_wr_ignored", 32'(ifa.Data_Out), 32'h0000);

    // Byte-enable merging on word 3.
    wr_a(16'd3, 2'b11, 16'hBEEF);
    check("a_wr_no_rv", 32'(ifa.Rd_Valid), 32'd0);
    wr_a(16'd3, 2'b01, 16'h1234);
    op_a(1, 0, 16'd3, 2'b00, 16'h0);
    check("a_be01", 32'(ifa.Data_Out), 32'hBE34);
    wr_a(16'd3, 2'b10, 16'h5600);
    op_a(1, 0, 16'd3, 2'b00, 16'h0);
    check("a_be10", 32'(ifa.Data_Out), 32'h5634);
    wr_a(16'd3, 2'b00, 16'hFFFF);
    check("a_be00_noerr", 32'(ifa.Addr_Err), 32'd0);
    op_a(1, 0, 16'd3, 2'b00, 16'h0);
    check("a_be00_nochange", 32'(ifa.Data_Out), 32'h5634);

    // Write then immediate read of the same word.
    wr_a(16'd7, 2'b11, 16'h0008);
    check("a_b2b_wr_rv", 32'(ifa.Rd_Valid), 32'd0);
    op_a(1, 0, 16'd7, 2'b00, 16'h0);
    check("a_b2b_dout", 32'(ifa.Data_Out), 32'h0008);
    check("a_b2b_rv", 32'(ifa.Rd_Valid), 32'd1);

    // Back-to-back reads of 0..3.
    wr_a(16'd0, 2'b11, 16'hC001);
    wr_a(16'd1, 2'b11, 16'hC102);
    wr_a(16'd2, 2'b11, 16'hC203);
    wr_a(16'd3, 2'b11, 16'hC304);
    op_a(1, 0, 16'd0, 2'b00, 16'h0);
    check("a_pipe0", {ifa.Rd_Valid, 15'h0, ifa.Data_Out}, {1'b1, 15'h0, 16'hC001});
    op_a(1, 0, 16'd1, 2'b00, 16'h0);
    check("a_pipe1", {ifa.Rd_Valid, 15'h0, ifa.Data_Out}, {1'b1, 15'h0, 16'hC102});
    op_a(1, 0, 16'd2, 2'b00, 16'h0);
    check("a_pipe2", {ifa.Rd_Valid, 15'h0, ifa.Data_Out}, {1'b1, 15'h0, 16'hC203});
    op_a(1, 0, 16'd3, 2'b00, 16'h0);
    check("a_pipe3", {ifa.Rd_Valid, 15'h0, ifa.Data_Out}, {1'b1, 15'h0, 16'hC304});
    op_a(0, 0, 16'd0, 2'b00, 16'h0);
    check("a_idle_rv", 32'(ifa.Rd_Valid), 32'd0);
    check("a_idle_hold", 32'(ifa.Data_Out), 32'hC304);

    // Out-of-range accesses.
    op_a(1, 0, 16'd64, 2'b00, 16'h0);
    check("a_oor_rd_err", 32'(ifa.Addr_Err), 32'd1);
    check("a_oor_rd_rv", 32'(ifa.Rd_Valid), 32'd1);
    check("a_oor_rd_dout", 32'(ifa.Data_Out), 32'h0000);
    op_a(0, 0, 16'd0, 2'b00, 16'h0);
    check("a_err_pulse", 32'(ifa.Addr_Err), 32'd0);
    wr_a(16'd100, 2'b11, 16'hFFFF);
    check("a_oor_wr_err", 32'(ifa.Addr_Err), 32'd1);
    check("a_oor_wr_rv", 32'(ifa.Rd_Valid), 32'd0);
    wr_a(16'h8005, 2'b11, 16'hFFFF);
    op_a(1, 0, 16'd63, 2'b00, 16'h0);
    check("a_last_noerr", 32'(ifa.Addr_Err), 32'd0);
    for (int i = 0; i < 64; i++) begin
      op_a(1, 0, 16'(i), 2'b00, 16'h0);
      check($sformatf("a_rb%0d", i), 32'(ifa.Data_Out), 32'(exp_a[i]));
    end

    // Reset while a read is presented, then reset again mid-sweep.
    wr_a(16'd40, 2'b11, 16'h1234);
    op_a(1, 0, 16'd40, 2'b00, 16'h0);
    check("a_w40", 32'(ifa.Data_Out), 32'h1234);
    rst_a_n = 0;
    op_a(1, 0, 16'd40, 2'b00, 16'h0);
    check("a_rst_rd_rv", 32'(ifa.Rd_Valid), 32'd0);
    check("a_rst_rd_dout", 32'(ifa.Data_Out), 32'h0000);
    check("a_rst_rd_ready", 32'(ifa.Ready), 32'd0);
    rst_a_n = 1;
    for (int i = 0; i < 30; i++) op_a(1, 0, 16'd40, 2'b00, 16'h0);
    check("a_mid_sweep_ready", 32'(ifa.Ready), 32'd0);
    rst_a_n = 0;
    op_a(0, 0, 16'd0, 2'b00, 16'h0);
    rst_a_n = 1;
    wait_ready_a(n, p);
    check("a_restart_latency", 32'(n), 32'd65);
    op_a(1, 0, 16'd40, 2'b00, 16'h0);
    check("a_restart_w40", 32'(ifa.Data_Out), 32'h0000);
    op_a(0, 0, 16'd0, 2'b00, 16'h0);

    // ---------------- DUT B: 32 x 16, no sweep ----------------
    check("b_rst_ready", 32'(ifb.Ready), 32'd0);
    check("b_rst_dout", ifb.Data_Out, 32'h0);
    rst_b_n = 1;
    tick();
    check("b_ready_lat", 32'(ifb.Ready), 32'd1);
    op_b(1, 1, 16'd2, 4'b1111, 32'h11223344);
    op_b(1, 1, 16'd2, 4'b1000, 32'hAA000000);
    op_b(1, 0, 16'd2, 4'b0000, 32'h0);
    check("b_be1000", ifb.Data_Out, 32'hAA223344);
    op_b(1, 1, 16'd15, 4'b1111, 32'hCAFEF00D);
    op_b(1, 0, 16'd15, 4'b0000, 32'h0);
    check("b_last_word", ifb.Data_Out, 32'hCAFEF00D);
    check("b_last_noerr", 32'(ifb.Addr_Err), 32'd0);
    op_b(1, 0, 16'd16, 4'b0000, 32'h0);
    check("b_oor_err", 32'(ifb.Addr_Err), 32'd1);
    check("b_oor_dout", ifb.Data_Out, 32'h0);
    rst_b_n = 0;
    op_b(1, 1, 16'd2, 4'b1111, 32'hFFFFFFFF);
    check("b_rst_ready2", 32'(ifb.Ready), 32'd0);
    rst_b_n = 1;
    op_b(0, 0, 16'd0, 4'b0000, 32'h0);
    op_b(1, 0, 16'd2, 4'b0000, 32'h0);
    check("b_rst_wr_dropped", ifb.Data_Out, 32'hAA223344);
    check("b_rst_wr_rv", 32'(ifb.Rd_Valid), 32'd1);
    op_b(0, 0, 16'd0, 4'b0000, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
